ps2_keystroke_tx: RTL
=====================

# ps2_keystroke_tx

Device-side PS/2 keystroke transmitter: accepts one ASCII character, converts it to its set-2 scan code, and serialises the make code, break prefix `F0` and make code onto PS/2 clock/data lines, as a keyboard would. It drives the keyboard receive path for closed-loop testing and demos. It also gives on-board key injection from the command/UART side, using the same character set the receive path decodes.

## Interface
Parameters:
- `HALF_PERIOD`, 4000: `clk` cycles per PS/2 clock half-period (100 MHz → 12.5 kHz).
- `GAP_CYCLES`, 8000: idle cycles, both lines high, after every byte frame.
- `SEND_BREAK`, 1: 1 = send make, `F0`, make; 0 = send make only.

Ports:
- `clk`, in, 1: system clock; single clock domain.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `ascii_code`, in, 8: character to send; sampled only on an accepted `start`.
- `start`, in, 1: request strobe; accepted only in IDLE.
- `busy`, out, 1: keystroke in progress; reset 0.
- `done_tick`, out, 1: one-cycle pulse when the sequence completes; reset 0.
- `unknown_tick`, out, 1: one-cycle pulse when `ascii_code` has no mapping; reset 0.
- `ps2c`, out, 1: PS/2 clock, push-pull model of the open-drain line; idle and reset 1.
- `ps2d`, out, 1: PS/2 data; idle and reset 1.

## Operation
- Character map (ASCII → scan code):
  - 21→05 (F1), 22→06 (F2)
  - 41→1C, 44→23, 46→2B, 48→33, 4D→3A
  - 52→2D, 53→1B, 54→2C
  - 0D→5A (Enter)
  - Every other value is unknown.
- Byte list:
  - `SEND_BREAK`=1: {code, F0, code}.
  - `SEND_BREAK`=0: {code}.
  - A 2-bit index tracks the current byte.
- Frame: 11 bits in this order:
  - start 0
  - data[0]..data[7], LSB first
  - odd parity `~^data`
  - stop 1
- FSM:
  - IDLE: `start`=1 with a known code → latch the code, index=0, go to BIT_HI. With an unknown code → pulse `unknown_tick`, stay in IDLE.
  - BIT_HI: `ps2d` = current bit, `ps2c`=1, for `HALF_PERIOD` cycles → BIT_LO.
  - BIT_LO: `ps2c`=0, `ps2d` held, for `HALF_PERIOD` cycles. Then, if bit<10: bit+1, go to BIT_HI; otherwise go to GAP.
  - GAP: `ps2c`=`ps2d`=1 for `GAP_CYCLES`. Then, if this is the last byte: go to IDLE and pulse `done_tick`. Otherwise: index+1, bit=0, go to BIT_HI.
- Data changes only while `ps2c` is high, so the receiver's falling-edge sample sees stable data.
- `start` is ignored while `busy`=1. No queueing, no error flag.
- `ascii_code` may change after acceptance without effect.

## Timing
- `start` sampled at edge k:
  - Known code: at k+1, `busy`=1, `ps2d`=0 (start bit), `ps2c`=1.
  - Unknown code: `unknown_tick`=1 at k+1 only, `busy` stays 0.
- One frame lasts 22·`HALF_PERIOD` cycles. One byte slot is 22·`HALF_PERIOD`+`GAP_CYCLES`.
- Total `busy` duration is N·(22·`HALF_PERIOD`+`GAP_CYCLES`) cycles, with N=3 or 1. The cycle after the last `busy` cycle has `busy`=0 and `done_tick`=1.
- A new `start` is accepted in the same cycle as `done_tick`.
- Counters use the smallest width ≥ clog2 of their maximum. Half-period and gap counters count to param−1 and wrap to 0.
- Reset asserted mid-frame: the lines go to 1 and all outputs go to their reset values immediately (asynchronous). The partial frame is abandoned and the FSM goes to IDLE.
- Parameters ≥ 1 are required.

## Structure
- Package `ps2_kbd_pkg`:
  - `BREAK_PREFIX` = 8'hF0
  - named ASCII and scan-code constants
  - FSM state enum {IDLE, BIT_HI, BIT_LO, GAP}
- Sub-module `ascii_to_keycode`: combinational lookup with outputs `key_code[7:0]` and `valid`. It is the exact inverse of the receive-path map for the keys listed.
- Top level holds the FSM, the bit, byte and timer counters, the frame shift register, and output registers. Registered outputs prevent glitches on `ps2c`/`ps2d`.

## Test plan
All scenarios use `HALF_PERIOD`=2, `GAP_CYCLES`=4 (frame 44 cycles, slot 48), a bench PS/2 receiver sampling on falling `ps2c`, and check parity and stop bit.
- `start` with 41 ('A') → bytes 1C (parity 0), F0 (parity 1), 1C. `busy` is high for 144 cycles; `done_tick` fires once, at k+145.
- `start` with 0D and `SEND_BREAK`=0 → the single byte 5A (parity 1). `busy` is high for 48 cycles.
- `start` with 5A ('Z') → `unknown_tick` at k+1. `busy` stays 0 and `ps2c`/`ps2d` stay 1.
- `start` pulsed again mid-sequence with 53 → ignored; only the original keystroke's bytes appear.
- `reset_n` low during the 2nd data bit of F0 → `ps2c`=`ps2d`=1 and `busy`=0 with no clock edge. After release, a new 'S' produces 1B, F0, 1B.
- `start` held high continuously with 22 → back-to-back keystrokes of 06, F0, 06. Each new keystroke begins in the cycle of `done_tick`, and data never changes while `ps2c`=0.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// Shared constants, types and helpers for the PS/2 keyboard paths.
package ps2_kbd_pkg;

    // Prefix byte sent before the repeated make code on key release.
    localparam logic [7:0] BREAK_PREFIX = 8'hF0;

    // ASCII characters with a key mapping.
    localparam logic [7:0] ASCII_F1    = 8'h21;
    localparam logic [7:0] ASCII_F2    = 8'h22;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_D     = 8'h44;
    localparam logic [7:0] ASCII_F     = 8'h46;
    localparam logic [7:0] ASCII_H     = 8'h48;
    localparam logic [7:0] ASCII_M     = 8'h4D;
    localparam logic [7:0] ASCII_R     = 8'h52;
    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_T     = 8'h54;
    localparam logic [7:0] ASCII_ENTER = 8'h0D;

    // Matching set-2 make codes.
    localparam logic [7:0] SC_F1    = 8'h05;
    localparam logic [7:0] SC_F2    = 8'h06;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_F     = 8'h2B;
    localparam logic [7:0] SC_H     = 8'h33;
    localparam logic [7:0] SC_M     = 8'h3A;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_T     = 8'h2C;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    // Bits per frame: start, 8 data, parity, stop.
    localparam int unsigned FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE,
        BIT_HI,
        BIT_LO,
        GAP
    } ps2_tx_state_t;

    // Frame laid out LSB-first as it goes on the wire: bit 0 is the start bit.
    function automatic logic [10:0] make_frame(input logic [7:0] data);
        return {1'b1, ~^data, data, 1'b0};
    endfunction

endpackage

// File: rtl/ascii_to_keycode.sv
// Combinational ASCII to set-2 make-code lookup, inverse of the receive-path map.
module ascii_to_keycode
    import ps2_kbd_pkg::*;
(
    input  logic [7:0] ascii_code,
    output logic [7:0] key_code,
    output logic       valid
);

    // Table lookup; anything not listed is reported as invalid.
    always_comb begin
        key_code = 8'h00;
        valid    = 1'b1;
        case (ascii_code)
            ASCII_F1:    key_code = SC_F1;
            ASCII_F2:    key_code = SC_F2;
            ASCII_A:     key_code = SC_A;
            ASCII_D:     key_code = SC_D;
            ASCII_F:     key_code = SC_F;
            ASCII_H:     key_code = SC_H;
            ASCII_M:     key_code = SC_M;
            ASCII_R:     key_code = SC_R;
            ASCII_S:     key_code = SC_S;
            ASCII_T:     key_code = SC_T;
            ASCII_ENTER: key_code = SC_ENTER;
            default:     valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_keystroke_tx.sv
// Device-side PS/2 keystroke transmitter: one ASCII character in, make/break bytes out.
module ps2_keystroke_tx
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 4000,
    parameter int unsigned GAP_CYCLES  = 8000,
    parameter bit          SEND_BREAK  = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] ascii_code,
    input  logic       start,
    output logic       busy,
    output logic       done_tick,
    output logic       unknown_tick,
    output logic       ps2c,
    output logic       ps2d
);

    // One timer serves both the half-period and the inter-frame gap.
    localparam int unsigned TMR_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(HALF_PERIOD - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [1:0]       LAST_IDX  = SEND_BREAK ? 2'd2 : 2'd0;
    localparam logic [3:0]       LAST_BIT  = 4'(FRAME_BITS - 1);

    ps2_tx_state_t    state;
    logic [3:0]       bit_cnt;
    logic [1:0]       byte_idx;
    logic [TMR_W-1:0] timer;
    logic [10:0]      frame;
    logic [7:0]       code;

    logic [7:0]       lut_code;
    logic             lut_valid;
    logic [7:0]       next_byte;

    ascii_to_keycode u_lut (
        .ascii_code (ascii_code),
        .key_code   (lut_code),
        .valid      (lut_valid)
    );

    // Byte that follows the current one: break prefix after the first, make code after that.
    always_comb begin
        next_byte = (byte_idx == 2'd0) ? BREAK_PREFIX : code;
    end

    // Keystroke sequencer; ps2c/ps2d are registered so the lines never glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            bit_cnt      <= 4'd0;
            byte_idx     <= 2'd0;
            timer        <= '0;
            frame        <= '1;
            code         <= 8'h00;
            busy         <= 1'b0;
            done_tick    <= 1'b0;
            unknown_tick <= 1'b0;
            ps2c         <= 1'b1;
            ps2d         <= 1'b1;
        end else begin
            done_tick    <= 1'b0;
            unknown_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (lut_valid) begin
                            code     <= lut_code;
                            frame    <= make_frame(lut_code);
                            byte_idx <= 2'd0;
                            bit_cnt  <= 4'd0;
                            timer    <= '0;
                            busy     <= 1'b1;
                            ps2c     <= 1'b1;
                            ps2d     <= 1'b0;
                            state    <= BIT_HI;
                        end else begin
                            unknown_tick <= 1'b1;
                        end
                    end
                end

                BIT_HI: begin
                    if (timer == HALF_LAST) begin
                        timer <= '0;
                        ps2c  <= 1'b0;
                        state <= BIT_LO;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                BIT_LO: begin
                    if (timer == HALF_LAST) begin
                        timer <= '0;
                        ps2c  <= 1'b1;
                        if (bit_cnt < LAST_BIT) begin
                            // Data moves only together with the rising clock edge.
                            bit_cnt <= bit_cnt + 4'd1;
                            frame   <= {1'b1, frame[10:1]};
                            ps2d    <= frame[1];
                            state   <= BIT_HI;
                        end else begin
                            ps2d  <= 1'b1;
                            state <= GAP;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                GAP: begin
                    if (timer == GAP_LAST) begin
                        timer <= '0;
                        if (byte_idx == LAST_IDX) begin
                            busy      <= 1'b0;
                            done_tick <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            bit_cnt  <= 4'd0;
                            frame    <= make_frame(next_byte);
                            ps2d     <= 1'b0;
                            state    <= BIT_HI;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
